div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//   Iterative signed/unsigned integer divider for the RV32M DIV/DIVU/REM/REMU ops.
//   Complements the single-cycle ALU: the execute stage issues divides here over a
//   valid/ready handshake and stalls on the result. Radix-2 restoring; one quotient bit/cycle.
// PARAMETERS
//   Width  32  operand/result width in bits; must be >= 2
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      request valid
//   in_ready   out  1      unit can accept a request (state IDLE)
//   op         in   2      2'b00 DIV, 2'b01 DIVU, 2'b10 REM, 2'b11 REMU
//   a          in   Width  dividend
//   b          in   Width  divisor
//   kill       in   1      synchronous abort (pipeline flush)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes result
//   result     out  Width  quotient (DIV/DIVU) or remainder (REM/REMU)
// BEHAVIOUR
// - Reset: state IDLE; out_valid=0; result=0; in_ready=1; internal regs cleared.
//   Reset mid-operation discards the op; no result is ever presented.
// - States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid at a clock edge: latch op, abs(a), abs(b) (abs only
//     for signed ops), result signs, count=Width-1; go to CALC.
//   CALC: per cycle: rem={rem[W-2:0],dvd[W-1]}; trial=rem-divisor; if trial>=0, rem=trial
//     and shift in q=1, else q=0. Count 0 -> FIX. Exactly Width cycles.
//   FIX: apply signs. Quotient negated if sign(a)!=sign(b) (signed). Remainder takes
//     sign of a (signed). Select result by op. Go to DONE.
//   DONE: out_valid=1; result held stable until out_ready. On out_ready: out_valid=0
//     next cycle; go to IDLE. No new accept in DONE; in_ready rises the cycle after the handshake.
// - Latency: accept edge E -> out_valid high from edge E+Width+2, i.e. Width+2 cycles
//   (34 for Width=32).
// - Special cases (RISC-V defined; no exceptions):
//   b==0: DIV/DIVU -> all ones; REM/REMU -> a.
//   DIV with a=most-negative and b=-1 -> a; REM for the same operands -> 0.
// - Arithmetic: internal remainder is Width+1 bits so the trial subtract carries
//   the sign. Magnitude of the most-negative value is representable as unsigned Width.
// - kill: highest priority, any state. The next state is IDLE. out_valid=0 next
//   cycle, result unchanged. in_valid in the same cycle as kill is ignored (not accepted).
// - result changes only on the FIX->DONE transition (or reset).
// CONFIGURATION
//   DIV_FAST_SPECIAL_EN defined: div-by-zero and signed overflow bypass CALC/FIX.
//     IDLE goes directly to DONE with the special result; out_valid is high from edge E+1.
//   Undefined: special cases traverse CALC and FIX and take full latency. FIX overrides
//     the result with the same special values. Results are bit-identical in both builds.
// TESTING (Width=32)
// - DIVU a=100 b=7 -> result=14, out_valid 34 cycles after accept; REMU same -> 2.
// - DIV a=-7 b=2 -> 0xFFFFFFFD; REM a=-7 b=2 -> 0xFFFFFFFF; REM a=7 b=-2 -> 1.
// - DIV a=5 b=0 -> 0xFFFFFFFF; REMU a=5 b=0 -> 5. Latency 1 with DIV_FAST_SPECIAL_EN,
//   34 without.
// - DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
// - Hold out_ready=0 for 10 cycles after out_valid: result stable, in_ready=0 throughout.
//   Then out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
// - kill 10 cycles into CALC -> out_valid never rises, in_ready=1 next cycle.
//   rst_n low mid-CALC -> out_valid=0 and result=0 immediately.

Source files
------------

// File: rtl/div_unit.sv
// =============================================================================
// div_unit
// -----------------------------------------------------------------------------
// Iterative radix-2 restoring integer divider for the RV32M DIV/DIVU/REM/REMU
// operations. The execute stage hands a request over a valid/ready handshake
// and stalls until the result is taken. One quotient bit is produced per
// cycle. The RISC-V special cases (divide by zero, signed overflow) never
// raise an exception; they return the architecturally defined values.
//
// Parameters:
//   Width      operand/result width in bits (>= 2)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   unit idle and able to accept a request
//   op         2'b00 DIV, 2'b01 DIVU, 2'b10 REM, 2'b11 REMU
//   a          dividend
//   b          divisor
//   kill       synchronous abort (pipeline flush), highest priority
//   out_valid  result valid
//   out_ready  consumer takes the result
//   result     quotient (DIV/DIVU) or remainder (REM/REMU)
//
// Configuration macro:
//   DIV_FAST_SPECIAL_EN  when defined, divide-by-zero and signed overflow skip
//                        the iteration and go straight to DONE, so out_valid
//                        rises one cycle after the accept. When undefined the
//                        special cases take the full latency and FIX
//                        substitutes the special value. Results are the same.
//
// Timing: a normal request accepted on edge E enters DONE on edge E+Width+1
// (Width CALC cycles plus one FIX cycle); out_valid is registered from DONE
// and is high from edge E+Width+2.
// =============================================================================
module div_unit #(
   parameter int Width = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [Width-1:0] a,
   input  logic [Width-1:0] b,
   input  logic             kill,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [Width-1:0] result
);

   localparam int CntW = $clog2(Width);
   localparam logic [Width-1:0] MinVal  = {1'b1, {(Width-1){1'b0}}};
   localparam logic [Width-1:0] AllOnes = {Width{1'b1}};
   localparam logic [CntW-1:0]  CntInit = CntW'(Width - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_e;

   state_e             state_q;
   logic               inReady_q;
   logic               outValid_q;
   logic [Width-1:0]   result_q;
   logic               opRem_q;
   logic               negQuot_q;
   logic               negRem_q;
   logic               special_q;
   logic [Width-1:0]   specialRes_q;
   logic [CntW-1:0]    cnt_q;
   logic [Width-1:0]   dvd_q;
   logic [Width-1:0]   divisor_q;
   logic [Width-1:0]   rem_q;

   // Request decode: signedness, operand magnitudes and the special-case
   // result, all evaluated on the raw inputs so they can be latched on accept.
   // Negating the most-negative value yields the same bit pattern, which is
   // its correct magnitude when read as unsigned.
   logic               isSigned;
   logic               aNeg;
   logic               bNeg;
   logic [Width-1:0]   aAbs;
   logic [Width-1:0]   bAbs;
   logic               divByZero;
   logic               sgnOverflow;
   logic               special;
   logic [Width-1:0]   specialRes;

   always_comb begin
      isSigned    = ~op[0];
      aNeg        = isSigned & a[Width-1];
      bNeg        = isSigned & b[Width-1];
      aAbs        = aNeg ? (~a + 1'b1) : a;
      bAbs        = bNeg ? (~b + 1'b1) : b;
      divByZero   = (b == '0);
      sgnOverflow = isSigned & (a == MinVal) & (b == AllOnes);
      special     = divByZero | sgnOverflow;
      specialRes  = '0;
      if (divByZero) begin
         specialRes = op[1] ? a : AllOnes;
      end else if (sgnOverflow) begin
         specialRes = op[1] ? '0 : MinVal;
      end
   end

   // One restoring step. The shifted partial remainder is Width+1 bits so the
   // trial subtraction carries its sign in the top bit; a clear top bit means
   // the divisor fit and a quotient one is shifted into the dividend register,
   // which doubles as the quotient register as the dividend bits drain out.
   logic [Width:0]     remShift;
   logic [Width:0]     trialDiff;
   logic               trialOk;

   always_comb begin
      remShift  = {rem_q, dvd_q[Width-1]};
      trialDiff = remShift - {1'b0, divisor_q};
      trialOk   = ~trialDiff[Width];
   end

   // Sign correction of the magnitude results for the signed operations.
   logic [Width-1:0]   quotFix;
   logic [Width-1:0]   remFix;

   always_comb begin
      quotFix = negQuot_q ? (~dvd_q + 1'b1) : dvd_q;
      remFix  = negRem_q ? (~rem_q + 1'b1) : rem_q;
   end

   // Control FSM with its registered outputs. kill overrides every state and
   // also suppresses an accept in the same cycle; result is left untouched by
   // kill so only FIX->DONE (or the fast special path) ever changes it.
   // out_valid is registered from DONE, so it rises one edge after DONE is
   // entered and a handshake is only possible once it is visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         inReady_q    <= 1'b1;
         outValid_q   <= 1'b0;
         result_q     <= '0;
         opRem_q      <= 1'b0;
         negQuot_q    <= 1'b0;
         negRem_q     <= 1'b0;
         special_q    <= 1'b0;
         specialRes_q <= '0;
         cnt_q        <= '0;
         dvd_q        <= '0;
         divisor_q    <= '0;
         rem_q        <= '0;
      end else if (kill) begin
         state_q    <= IDLE;
         inReady_q  <= 1'b1;
         outValid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  opRem_q      <= op[1];
                  negQuot_q    <= aNeg ^ bNeg;
                  negRem_q     <= aNeg;
                  special_q    <= special;
                  specialRes_q <= specialRes;
                  dvd_q        <= aAbs;
                  divisor_q    <= bAbs;
                  rem_q        <= '0;
                  cnt_q        <= CntInit;
                  inReady_q    <= 1'b0;
`ifdef DIV_FAST_SPECIAL_EN
                  if (special) begin
                     result_q <= specialRes;
                     state_q  <= DONE;
                  end else begin
                     state_q  <= CALC;
                  end
`else
                  state_q      <= CALC;
`endif
               end
            end

            CALC: begin
               rem_q <= trialOk ? trialDiff[Width-1:0] : remShift[Width-1:0];
               dvd_q <= {dvd_q[Width-2:0], trialOk};
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_q <= FIX;
               end
            end

            FIX: begin
               if (special_q) begin
                  result_q <= specialRes_q;
               end else begin
                  result_q <= opRem_q ? remFix : quotFix;
               end
               state_q <= DONE;
            end

            DONE: begin
               if (!outValid_q) begin
                  outValid_q <= 1'b1;
               end else if (out_ready) begin
                  outValid_q <= 1'b0;
                  inReady_q  <= 1'b1;
                  state_q    <= IDLE;
               end
            end

            default: begin
               state_q    <= IDLE;
               inReady_q  <= 1'b1;
               outValid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = inReady_q;
   assign out_valid = outValid_q;
   assign result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// =============================================================================
// tb_div_unit
// -----------------------------------------------------------------------------
// Directed testbench for div_unit at Width=32. Expected results are pushed to
// a queue when a request is issued and popped when out_valid appears. Inputs
// are driven and outputs sampled 1ns after the rising clock edge.
// =============================================================================
module tb_div_unit;

   localparam int W = 32;
   localparam logic [W-1:0] MinVal = 32'h8000_0000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    op = 2'b00;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          kill = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  result;

   int            assertCount = 0;
   int            failCount = 0;
   logic [W-1:0]  expQ[$];
   logic [W-1:0]  lastExp = '0;

   div_unit #(.Width(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .kill      (kill),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   // Free-running 100MHz clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports failures.
   task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Reference model built on the language's own signed/unsigned operators
   // plus the RISC-V special cases.
   function automatic logic [W-1:0] refModel(input logic [1:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
      logic [W-1:0] r;
      case (o)
         2'b00: begin
            if (y == '0) r = '1;
            else if (x == MinVal && y == '1) r = x;
            else r = $signed(x) / $signed(y);
         end
         2'b01: r = (y == '0) ? '1 : x / y;
         2'b10: begin
            if (y == '0) r = x;
            else if (x == MinVal && y == '1) r = '0;
            else r = $signed(x) % $signed(y);
         end
         default: r = (y == '0) ? x : x % y;
      endcase
      return r;
   endfunction

   function automatic int expLatency(input logic [1:0] o, input logic [W-1:0] x,
                                     input logic [W-1:0] y);
      bit sp;
      sp = (y == '0) || (!o[0] && x == MinVal && y == '1);
`ifdef DIV_FAST_SPECIAL_EN
      return sp ? 1 : W + 2;
`else
      return sp ? W + 2 : W + 2;
`endif
   endfunction

   // Issue one request; called 1ns after a rising edge, returns 1ns after the
   // accept edge with in_valid dropped.
   task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x,
                                input logic [W-1:0] y);
      op       = o;
      a        = x;
      b        = y;
      in_valid = 1'b1;
      checkOutput("in_ready_at_issue", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for out_valid, check latency and the popped expectation,
   // optionally stall the consumer, then complete the handshake.
   task automatic collectResult(input string tag, input int expLat, input int holdCycles);
      int           lat;
      logic [W-1:0] exp;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!out_valid && lat < 100);
      checkOutput({tag, "_latency"}, W'(lat), W'(expLat));
      if (expQ.size() == 0) begin
         checkOutput({tag, "_scoreboard"}, W'(expQ.size()), 32'd1);
         exp = '0;
      end else begin
         exp = expQ.pop_front();
         checkOutput(tag, result, exp);
      end
      lastExp = exp;
      for (int i = 0; i < holdCycles; i++) begin
         @(posedge clk);
         #1;
         checkOutput({tag, "_hold_result"}, result, exp);
         checkOutput({tag, "_hold_out_valid"}, {31'b0, out_valid}, 32'd1);
         checkOutput({tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, "_out_valid_drop"}, {31'b0, out_valid}, 32'd0);
      checkOutput({tag, "_in_ready_rise"}, {31'b0, in_ready}, 32'd1);
   endtask

   // Request, expectation push and collection in one step.
   task automatic runOp(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] expected,
                        input int holdCycles);
      applyStimulus(o, x, y);
      expQ.push_back(expected);
      collectResult(tag, expLatency(o, x, y), holdCycles);
   endtask

   initial begin
      int            sawValid;
      logic [1:0]    rop;
      logic [W-1:0]  ra;
      logic [W-1:0]  rb;

      $display("[TB] starting div_unit test");

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset_result", result, 32'd0);
      checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed arithmetic and special cases.
      runOp("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 0);
      runOp("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 0);
      runOp("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
      runOp("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
      runOp("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 0);
      runOp("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
      runOp("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 0);
      runOp("div_m5_0", 2'b00, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 0);
      runOp("rem_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0);
      runOp("div_ovf", 2'b00, MinVal, 32'hFFFF_FFFF, MinVal, 0);
      runOp("rem_ovf", 2'b10, MinVal, 32'hFFFF_FFFF, 32'd0, 0);
      runOp("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0);

      // Consumer stall: result and flags held for 10 cycles.
      runOp("hold_divu", 2'b01, 32'd1000, 32'd10, 32'd100, 10);

      // Asynchronous reset in the middle of CALC.
      applyStimulus(2'b01, 32'd12345, 32'd3);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("rst_mid_result", result, 32'd0);
      checkOutput("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Random requests checked against the reference model.
      for (int i = 0; i < 8; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : $urandom;
         runOp($sformatf("rand_%0d_op%0d", i, rop), rop, ra, rb, refModel(rop, ra, rb), 0);
      end

      // kill 10 cycles into CALC, with a simultaneous in_valid that must be ignored.
      applyStimulus(2'b00, 32'd99999, 32'd7);
      repeat (10) @(posedge clk);
      #1;
      kill     = 1'b1;
      in_valid = 1'b1;
      op       = 2'b01;
      a        = 32'd50;
      b        = 32'd5;
      @(posedge clk);
      #1;
      kill     = 1'b0;
      in_valid = 1'b0;
      checkOutput("kill_in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("kill_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("kill_result_kept", result, lastExp);
      sawValid = 0;
      for (int i = 0; i < 45; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) sawValid++;
      end
      checkOutput("kill_no_out_valid", W'(sawValid), 32'd0);
      checkOutput("kill_idle_after", {31'b0, in_ready}, 32'd1);

      // Unit still works after the flush.
      runOp("after_kill_rem", 2'b10, 32'hFFFF_FF9C, 32'd7, refModel(2'b10, 32'hFFFF_FF9C, 32'd7), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
